motor_pwm_bank: RTL and testbench

Multi-channel PWM generator for the motor driver stage. All channels share one timebase: a clock prescaler feeding a period tick counter. Each channel has a double-buffered duty register, so a new duty never takes effect mid-period and the outputs do not glitch. It drives H-bridge enable inputs and is written by the motor control logic through a load strobe.

---
 rtl/motor_pwm_bank_pkg.sv | 23 ++
 rtl/motor_pwm_bank_pwm_channel.sv | 71 +++++++
 rtl/motor_pwm_bank.sv | 89 ++++++++
 tb/tb_motor_pwm_bank.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pwm_bank_pkg.sv
// Shared definitions for the motor PWM bank: default widths, duty type and
// helpers that size the timebase counters.
package motor_pkg;

  localparam int unsigned DUTY_W_DEF = 7;
  localparam int unsigned PERIOD_DEF = 100;

  typedef logic [DUTY_W_DEF-1:0] duty_t;

  // Duty value that keeps a channel high for the whole period
  localparam int unsigned DUTY_FULL = PERIOD_DEF;

  // Prescaler counter width; a prescale of 1 still needs a 1-bit register
  function automatic int unsigned presc_width(input int unsigned prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

  // Tick counter shares the duty field width so compares line up
  function automatic int unsigned tick_width(input int unsigned duty_w);
    return duty_w;
  endfunction

endpackage

// File: rtl/motor_pwm_bank_pwm_channel.sv
// One PWM channel: shadow duty, active duty, saturation and the registered
// compare output. Optional soft start under MOTOR_PWM_RAMP_EN.
module pwm_channel
  import motor_pkg::*;
#(
  parameter int unsigned DUTY_W = DUTY_W_DEF,
  parameter int unsigned PERIOD = DUTY_FULL
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              i_enable,
  input  logic              i_load_evt,
  input  logic [DUTY_W-1:0] i_duty,
  input  logic              i_duty_load,
  input  logic [DUTY_W-1:0] i_tick_n,
  output logic              o_pwm
);

  // One extra bit so PERIOD == 2**DUTY_W is representable
  localparam int unsigned AW = DUTY_W + 1;
  localparam logic [AW-1:0] FULL = AW'(PERIOD);

  logic [AW-1:0] r_shadow;
  logic [AW-1:0] r_active;
  logic          r_pwm;
  logic [AW-1:0] w_dsat;
  logic [AW-1:0] w_target;
  logic [AW-1:0] w_active_n;
  logic          w_pwm_n;

  // Saturate the incoming duty, pick the load target and the next active duty
  always_comb begin
    w_dsat   = ({1'b0, i_duty} >= FULL) ? FULL : {1'b0, i_duty};
    // A load coinciding with a period start bypasses the shadow register
    w_target = i_duty_load ? w_dsat : r_shadow;
`ifdef MOTOR_PWM_RAMP_EN
    w_active_n = r_active;
    if (!i_enable) begin
      w_active_n = '0;
    end else if (i_load_evt) begin
      if (r_active < w_target) begin
        w_active_n = r_active + 1'b1;
      end else if (r_active > w_target) begin
        w_active_n = r_active - 1'b1;
      end
    end
`else
    w_active_n = i_load_evt ? w_target : r_active;
`endif
    // Compare against next-state tick and duty so the output is registered
    w_pwm_n = i_enable && ({1'b0, i_tick_n} < w_active_n);
  end

  // Shadow, active and output registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_shadow <= '0;
      r_active <= '0;
      r_pwm    <= 1'b0;
    end else begin
      if (i_duty_load) begin
        r_shadow <= w_dsat;
      end
      r_active <= w_active_n;
      r_pwm    <= w_pwm_n;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/motor_pwm_bank.sv
// Multi-channel motor PWM bank: shared prescaler/tick timebase feeding
// double-buffered per-channel comparators. Define MOTOR_PWM_RAMP_EN for
// soft-start ramping of the active duties.
module motor_pwm_bank
  import motor_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DUTY_W   = DUTY_W_DEF,
  parameter int unsigned PRESCALE = 1000,
  parameter int unsigned PERIOD   = DUTY_FULL
) (
  input  logic                       Clock,
  input  logic                       Reset,
  input  logic                       enable_i,
  input  logic [CHANNELS*DUTY_W-1:0] duty_i,
  input  logic                       duty_load_i,
  output logic [CHANNELS-1:0]        pwm_o,
  output logic                       period_tick_o
);

  localparam int unsigned PW = presc_width(PRESCALE);
  localparam int unsigned TW = tick_width(DUTY_W);
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
  localparam logic [TW-1:0] TICK_LAST  = TW'(PERIOD - 1);

  logic [PW-1:0] r_presc;
  logic [TW-1:0] r_tick;
  logic          r_en;
  logic          r_period_tick;
  logic [PW-1:0] w_presc_n;
  logic [TW-1:0] w_tick_n;
  logic          w_tick_en;
  logic          w_restart;
  logic          w_boundary;
  logic          w_load_evt;

  // Next-state timebase; a rising enable restarts at tick 0 like a boundary
  always_comb begin
    w_tick_en  = (r_presc == PRESC_LAST);
    w_restart  = enable_i && !r_en;
    w_boundary = enable_i && r_en && w_tick_en && (r_tick == TICK_LAST);
    w_load_evt = w_restart || w_boundary;
    w_presc_n  = '0;
    w_tick_n   = '0;
    if (enable_i && r_en) begin
      if (w_tick_en) begin
        w_presc_n = '0;
        w_tick_n  = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
      end else begin
        w_presc_n = r_presc + 1'b1;
        w_tick_n  = r_tick;
      end
    end
  end

  // Timebase registers and the period-start pulse
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_presc       <= '0;
      r_tick        <= '0;
      r_en          <= 1'b0;
      r_period_tick <= 1'b0;
    end else begin
      r_presc       <= w_presc_n;
      r_tick        <= w_tick_n;
      r_en          <= enable_i;
      r_period_tick <= enable_i && (w_tick_n == '0) && (w_presc_n == '0);
    end
  end

  assign period_tick_o = r_period_tick;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pwm_channel #(
      .DUTY_W (DUTY_W),
      .PERIOD (PERIOD)
    ) u_ch (
      .Clock       (Clock),
      .Reset       (Reset),
      .i_enable    (enable_i),
      .i_load_evt  (w_load_evt),
      .i_duty      (duty_i[g*DUTY_W +: DUTY_W]),
      .i_duty_load (duty_load_i),
      .i_tick_n    (w_tick_n),
      .o_pwm       (pwm_o[g])
    );
  end

endmodule

// File: tb/tb_motor_pwm_bank.sv
// Directed bench for motor_pwm_bank with PRESCALE=4, PERIOD=10 (40-clock period).
module tb_motor_pwm_bank;

  localparam int unsigned CH = 2;
  localparam int unsigned DW = 7;

  logic               Clock = 1'b0;
  logic               Reset;
  logic               enable_i;
  logic [CH*DW-1:0]   duty_i;
  logic               duty_load_i;
  logic [CH-1:0]      pwm_o;
  logic               period_tick_o;

  int checks = 0;
  int errors = 0;

  always #5 Clock = ~Clock;

  motor_pwm_bank #(
    .CHANNELS (2),
    .DUTY_W   (7),
    .PRESCALE (4),
    .PERIOD   (10)
  ) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .enable_i      (enable_i),
    .duty_i        (duty_i),
    .duty_load_i   (duty_load_i),
    .pwm_o         (pwm_o),
    .period_tick_o (period_tick_o)
  );

  function automatic logic [CH*DW-1:0] pack(input int unsigned d1, input int unsigned d0);
    return {7'(d1), 7'(d0)};
  endfunction

  task automatic load_duty(input logic [CH*DW-1:0] val);
    duty_i      = val;
    duty_load_i = 1'b1;
    @(negedge Clock);
    duty_load_i = 1'b0;
  endtask

  // Advance to the next period-start cycle, bounded
  task automatic wait_ptick();
    int n = 0;
    while (period_tick_o !== 1'b1 && n < 100) begin
      @(negedge Clock);
      n++;
    end
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL wait_ptick: period_tick_o=%b after %0d cycles, required 1", period_tick_o, n);
    end
  endtask

  // Count high clocks per channel over one 40-clock period starting now
  task automatic measure(input int load_at, input logic [CH*DW-1:0] val,
                         output int hi0, output int hi1);
    hi0 = 0;
    hi1 = 0;
    for (int k = 0; k < 40; k++) begin
      if (k == load_at) begin
        duty_i      = val;
        duty_load_i = 1'b1;
      end else begin
        duty_load_i = 1'b0;
      end
      if (pwm_o[0] === 1'b1) hi0++;
      if (pwm_o[1] === 1'b1) hi1++;
      @(negedge Clock);
    end
    duty_load_i = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    Reset = 1'b0; enable_i = 1'b0; duty_i = '0; duty_load_i = 1'b0;
    repeat (3) @(negedge Clock);
    checks++;
    if (pwm_o !== 2'b00 || period_tick_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pwm_o=%b tick=%b, required 00/0", pwm_o, period_tick_o);
    end
    Reset = 1'b1; enable_i = 1'b1;
    load_duty(pack(5, 5));
    checks++;
    if (period_tick_o !== 1'b1 || pwm_o !== 2'b11) begin
      errors++;
      $display("FAIL first_enable: tick=%b pwm_o=%b, required 1/11", period_tick_o, pwm_o);
    end
    repeat (23) @(negedge Clock);
    Reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      checks++;
      if (pwm_o !== 2'b00 || period_tick_o !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset%0d: pwm_o=%b tick=%b, required 00/0", k, pwm_o, period_tick_o);
      end
    end
    Reset = 1'b1;
    @(negedge Clock);
    checks++;
    if (period_tick_o !== 1'b1 || pwm_o !== 2'b00) begin
      errors++;
      $display("FAIL restart: tick=%b pwm_o=%b, required 1/00", period_tick_o, pwm_o);
    end
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        @(negedge Clock);
        n++;
      end while (period_tick_o !== 1'b1 && n < 100);
      checks++;
      if (n != 40) begin
        errors++;
        $display("FAIL tick_spacing%0d: %0d cycles, required 40", p, n);
      end
    end
  endtask

  task automatic test_basic_duty();
    logic [1:0] first;
    int h0, h1;
    load_duty(pack(7, 3));
    wait_ptick();
    first = pwm_o;
    measure(-1, '0, h0, h1);
    checks++;
    if (first !== 2'b11) begin
      errors++;
      $display("FAIL basic_rise: pwm_o=%b at period start, required 11", first);
    end
    checks++;
    if (h0 != 12 || h1 != 28) begin
      errors++;
      $display("FAIL basic_high: ch0=%0d ch1=%0d, required 12/28", h0, h1);
    end
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL basic_next_tick: tick=%b, required 1", period_tick_o);
    end
  endtask

  task automatic test_extremes();
    int h0, h1;
    load_duty(pack(10, 0));
    wait_ptick();
    for (int p = 0; p < 3; p++) begin
      measure(-1, '0, h0, h1);
      checks++;
      if (h0 != 0 || h1 != 40) begin
        errors++;
        $display("FAIL full10_p%0d: ch0=%0d ch1=%0d, required 0/40", p, h0, h1);
      end
    end
    load_duty(pack(127, 0));
    wait_ptick();
    for (int p = 0; p < 3; p++) begin
      measure(-1, '0, h0, h1);
      checks++;
      if (h0 != 0 || h1 != 40) begin
        errors++;
        $display("FAIL sat127_p%0d: ch0=%0d ch1=%0d, required 0/40", p, h0, h1);
      end
    end
  endtask

  task automatic test_double_buffer();
    int h0, h1;
    load_duty(pack(3, 3));
    wait_ptick();
    measure(20, pack(3, 8), h0, h1);
    checks++;
    if (h0 != 12 || h1 != 12) begin
      errors++;
      $display("FAIL midload_current: ch0=%0d ch1=%0d, required 12/12", h0, h1);
    end
    measure(39, pack(3, 2), h0, h1);
    checks++;
    if (h0 != 32 || h1 != 12) begin
      errors++;
      $display("FAIL midload_next: ch0=%0d ch1=%0d, required 32/12", h0, h1);
    end
    measure(-1, '0, h0, h1);
    checks++;
    if (h0 != 8 || h1 != 12) begin
      errors++;
      $display("FAIL boundary_bypass: ch0=%0d ch1=%0d, required 8/12", h0, h1);
    end
  endtask

  task automatic test_enable();
    int h0, h1, bad;
    repeat (2) @(negedge Clock);
    checks++;
    if (pwm_o !== 2'b11) begin
      errors++;
      $display("FAIL pre_disable: pwm_o=%b, required 11", pwm_o);
    end
    enable_i = 1'b0;
    @(negedge Clock);
    checks++;
    if (pwm_o !== 2'b00 || period_tick_o !== 1'b0 || dut.r_presc !== 2'd0 || dut.r_tick !== 7'd0) begin
      errors++;
      $display("FAIL disable: pwm_o=%b tick=%b presc=%0d tcnt=%0d, required 00/0/0/0",
               pwm_o, period_tick_o, dut.r_presc, dut.r_tick);
    end
    bad = 0;
    for (int k = 0; k < 16; k++) begin
      duty_i      = pack(0, 4);
      duty_load_i = (k == 0);
      @(negedge Clock);
      if (pwm_o !== 2'b00 || period_tick_o !== 1'b0) bad++;
    end
    duty_load_i = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL disabled_quiet: %0d active cycles, required 0", bad);
    end
    enable_i = 1'b1;
    @(negedge Clock);
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL reenable_tick: tick=%b, required 1", period_tick_o);
    end
    measure(-1, '0, h0, h1);
    checks++;
    if (h0 != 16 || h1 != 0 || period_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL reenable_period: ch0=%0d ch1=%0d tick=%b, required 16/0/1", h0, h1, period_tick_o);
    end
  endtask

`ifdef MOTOR_PWM_RAMP_EN
  task automatic test_ramp();
    int h0, h1;
    int up [6] = '{4, 8, 12, 16, 20, 20};
    int dn [4] = '{16, 12, 8, 8};
    enable_i = 1'b0;
    load_duty(pack(5, 5));
    @(negedge Clock);
    enable_i = 1'b1;
    @(negedge Clock);
    checks++;
    if (period_tick_o !== 1'b1) begin
      errors++;
      $display("FAIL ramp_start: tick=%b, required 1", period_tick_o);
    end
    for (int p = 0; p < 6; p++) begin
      measure(-1, '0, h0, h1);
      checks++;
      if (h0 != up[p] || h1 != up[p]) begin
        errors++;
        $display("FAIL ramp_up%0d: ch0=%0d ch1=%0d, required %0d", p, h0, h1, up[p]);
      end
    end
    measure(5, pack(2, 2), h0, h1);
    checks++;
    if (h0 != 20 || h1 != 20) begin
      errors++;
      $display("FAIL ramp_hold: ch0=%0d ch1=%0d, required 20", h0, h1);
    end
    for (int p = 0; p < 4; p++) begin
      measure(-1, '0, h0, h1);
      checks++;
      if (h0 != dn[p] || h1 != dn[p]) begin
        errors++;
        $display("FAIL ramp_down%0d: ch0=%0d ch1=%0d, required %0d", p, h0, h1, dn[p]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_duty();
    test_extremes();
    test_double_buffer();
    test_enable();
`ifdef MOTOR_PWM_RAMP_EN
    test_ramp();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
